// File: rtl/gb_oam_dma_pkg.sv
// Shared types and constants for the OAM DMA sequencer and its source-address remap.
// Contents: 2-bit state encoding, default transfer length, echo-RAM remap constants,
// and the bit offsets of the optional savestate word (OAM_DMA_SAVESTATE_EN).
package gb_oam_dma_pkg;

    // State encoding, kept as plain 2-bit constants so the value can be packed
    // into and restored from the savestate word.
    typedef logic [1:0] dma_state_t;
    localparam dma_state_t ST_IDLE    = 2'd0;
    localparam dma_state_t ST_START   = 2'd1;
    localparam dma_state_t ST_XFER    = 2'd2;
    localparam dma_state_t ST_RESTART = 2'd3;

    localparam int OAM_BYTES_DEF = 160;

    // Source pages E0-FF alias the work RAM at C0-DF.
    localparam logic [7:0] ECHO_BASE = 8'hE0;
    localparam logic [7:0] ECHO_OFS  = 8'h20;

    // Savestate word: {state, delay_cnt, pending_hi, index, src_hi, 4'h0}.
    localparam int SS_STATE_LSB = 30;
    localparam int SS_DLY_LSB   = 28;
    localparam int SS_PEND_LSB  = 20;
    localparam int SS_IDX_LSB   = 12;
    localparam int SS_SRC_LSB   = 4;

endpackage

// File: rtl/oam_dma_src_map.sv
// Source-bus address generation: echo-RAM remap of the source page plus byte index.
// Ports: src_hi (raw FF46 page), index (byte within page) -> src_addr (16-bit bus address).
// Purely combinational, no clock, no backpressure.
module oam_dma_src_map
    import gb_oam_dma_pkg::*;
(
    input  logic [7:0]  src_hi,
    input  logic [7:0]  index,
    output logic [15:0] src_addr
);

    logic [7:0] eff_hi;

    always_comb begin
        eff_hi = src_hi;
        if (src_hi >= ECHO_BASE) begin
            eff_hi = src_hi - ECHO_OFS;
        end
    end

    assign src_addr = {eff_hi, index};

endmodule

// File: rtl/oam_dma_ctrl.sv
// OAM DMA sequencer (FF46): copies OAM_BYTES bytes from {src_hi,00h} into OAM, one byte per ce.
// Ports: clk/reset (sync, active-high), ce, FF46 write/readback, source bus address/data,
// OAM write port, dma_active. Optional savestate ports when OAM_DMA_SAVESTATE_EN is defined.
module oam_dma_ctrl
    import gb_oam_dma_pkg::*;
#(
    parameter int OAM_BYTES   = OAM_BYTES_DEF,
    parameter int START_DELAY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ce,
    input  logic        reg_wr,
    input  logic [7:0]  reg_di,
    output logic [7:0]  reg_do,
    output logic [15:0] dma_src_addr,
    input  logic [7:0]  dma_rd_data,
`ifdef OAM_DMA_SAVESTATE_EN
    input  logic        ss_load,
    input  logic [31:0] ss_in,
    output logic [31:0] ss_out,
`endif
    output logic        dma_active,
    output logic        oam_wr,
    output logic [7:0]  oam_addr,
    output logic [7:0]  oam_di
);

    localparam logic [7:0] LAST_IDX = 8'(OAM_BYTES - 1);
    localparam logic [1:0] DLY_LAST = 2'(START_DELAY - 1);

    dma_state_t state_q, state_d;
    logic [7:0] index_q, index_d;
    logic [7:0] src_hi_q, src_hi_d;
    logic [7:0] pending_hi_q, pending_hi_d;
    logic [1:0] delay_cnt_q, delay_cnt_d;
    logic [7:0] reg_do_q, reg_do_d;
    logic       dma_active_q, dma_active_d;
    logic       wr_now;

    always_comb begin
        state_d      = state_q;
        index_d      = index_q;
        src_hi_d     = src_hi_q;
        pending_hi_d = pending_hi_q;
        delay_cnt_d  = delay_cnt_q;
        reg_do_d     = reg_do_q;
        wr_now       = 1'b0;

        if (ce) begin
            case (state_q)
                ST_IDLE: begin
                    if (reg_wr) begin
                        src_hi_d    = reg_di;
                        reg_do_d    = reg_di;
                        delay_cnt_d = 2'd0;
                        index_d     = 8'd0;
                        state_d     = (START_DELAY == 0) ? ST_XFER : ST_START;
                    end
                end
                ST_START: begin
                    if (reg_wr) begin
                        // A second write restarts the delay from scratch with the new page.
                        src_hi_d    = reg_di;
                        reg_do_d    = reg_di;
                        delay_cnt_d = 2'd0;
                    end else if (delay_cnt_q == DLY_LAST) begin
                        delay_cnt_d = 2'd0;
                        index_d     = 8'd0;
                        state_d     = ST_XFER;
                    end else begin
                        delay_cnt_d = delay_cnt_q + 2'd1;
                    end
                end
                ST_XFER: begin
                    wr_now = 1'b1;
                    if (reg_wr) begin
                        pending_hi_d = reg_di;
                        reg_do_d     = reg_di;
                        state_d      = ST_RESTART;
                        // In RESTART delay_cnt[0] marks an exhausted old stream, so
                        // the index never has to step past the last byte.
                        if (index_q == LAST_IDX) begin
                            delay_cnt_d = 2'd1;
                        end else begin
                            delay_cnt_d = 2'd0;
                            index_d     = index_q + 8'd1;
                        end
                    end else if (index_q == LAST_IDX) begin
                        index_d = 8'd0;
                        state_d = ST_IDLE;
                    end else begin
                        index_d = index_q + 8'd1;
                    end
                end
                default: begin // ST_RESTART
                    // One more byte from the old stream, then switch to the new page.
                    wr_now = (delay_cnt_q == 2'd0);
                    if (reg_wr) begin
                        pending_hi_d = reg_di;
                        reg_do_d     = reg_di;
                    end
                    src_hi_d    = reg_wr ? reg_di : pending_hi_q;
                    index_d     = 8'd0;
                    delay_cnt_d = 2'd0;
                    state_d     = ST_XFER;
                end
            endcase

`ifdef OAM_DMA_SAVESTATE_EN
            if (ss_load) begin
                state_d      = ss_in[SS_STATE_LSB +: 2];
                delay_cnt_d  = ss_in[SS_DLY_LSB +: 2];
                pending_hi_d = ss_in[SS_PEND_LSB +: 8];
                index_d      = ss_in[SS_IDX_LSB +: 8];
                src_hi_d     = ss_in[SS_SRC_LSB +: 8];
                // The last FF46 write is the pending page during a restart, else src_hi.
                reg_do_d     = (ss_in[SS_STATE_LSB +: 2] == ST_RESTART) ?
                               ss_in[SS_PEND_LSB +: 8] : ss_in[SS_SRC_LSB +: 8];
                wr_now       = 1'b0;
            end
`endif
        end

        dma_active_d = (state_d == ST_XFER) || (state_d == ST_RESTART);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            index_q      <= 8'd0;
            src_hi_q     <= 8'hFF;
            pending_hi_q <= 8'hFF;
            delay_cnt_q  <= 2'd0;
            reg_do_q     <= 8'hFF;
            dma_active_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            index_q      <= index_d;
            src_hi_q     <= src_hi_d;
            pending_hi_q <= pending_hi_d;
            delay_cnt_q  <= delay_cnt_d;
            reg_do_q     <= reg_do_d;
            dma_active_q <= dma_active_d;
        end
    end

    oam_dma_src_map u_src_map (
        .src_hi   (src_hi_q),
        .index    (index_q),
        .src_addr (dma_src_addr)
    );

    assign reg_do     = reg_do_q;
    assign dma_active = dma_active_q;
    assign oam_wr     = wr_now;
    assign oam_addr   = index_q;
    assign oam_di     = wr_now ? dma_rd_data : 8'h00;

`ifdef OAM_DMA_SAVESTATE_EN
    logic unused_ss_pad;
    assign unused_ss_pad = ^ss_in[3:0];
    assign ss_out = {state_q, delay_cnt_q, pending_hi_q, index_q, src_hi_q, 4'h0};
`endif

endmodule
